// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Define IFETCH_SKID_EN for a 2-entry fetch buffer (1 instr/cycle); default is 1 entry.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000015;

`ifdef IFETCH_SKID_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {RESET, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/ifetch_buffer.sv
// Fetch buffer: 1- or 2-entry FIFO of {word, pc}; depth follows IFETCH_SKID_EN.
// Head is entry 0; flush takes priority over enqueue and dequeue.
module ifetch_buffer
    import ifetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  entry_t           enq_data,
    input  logic             deq,
    input  logic             flush,
    output entry_t           head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    entry_t           mem     [BUF_DEPTH];
    entry_t           mem_nxt [BUF_DEPTH];
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        mem_nxt = mem;
        cnt_nxt = count;
        if (flush) begin
            cnt_nxt = '0;
        end else begin
            if (deq && count != '0) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) mem_nxt[i] = mem[i + 1];
                cnt_nxt = cnt_nxt - CNT_W'(1);
            end
            // Write lands in the first free slot after any dequeue shift.
            if (enq) begin
                for (int i = 0; i < BUF_DEPTH; i++)
                    if (cnt_nxt == CNT_W'(i)) mem_nxt[i] = enq_data;
                cnt_nxt = cnt_nxt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            count <= cnt_nxt;
            mem   <= mem_nxt;
        end
    end

    assign head       = mem[0];
    assign head_valid = (count != '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and applies
// delay-slot-preserving redirects. Buffer depth set by IFETCH_SKID_EN (see ifetch_pkg).
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] delay,
    output logic [31:0] delay2,
    output logic        bubble
);

    state_t           state, state_nxt;
    logic [31:0]      fpc, fpc_nxt;
    logic [31:0]      ptgt, ptgt_nxt;
    logic             pend, pend_nxt;
    entry_t           head;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             enq, deq, flush, accept, take_redir;
    logic [31:0]      tgt;
    logic             unused_tgt_lsb;

    assign tgt            = {redirect_target[31:2], 2'b00};
    assign unused_tgt_lsb = ^redirect_target[1:0];
    assign take_redir     = redirect && !stall;
    assign deq            = head_valid && !stall;
    assign accept         = imem_req && imem_ack;
    assign imem_addr      = fpc;

    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        ptgt_nxt  = ptgt;
        pend_nxt  = pend;
        imem_req  = 1'b0;
        enq       = 1'b0;
        flush     = 1'b0;
        case (state)
            RESET: state_nxt = FETCH;
            FETCH: begin
                imem_req = (count != CNT_W'(BUF_DEPTH));
                if (accept) begin
                    enq      = 1'b1;
                    fpc_nxt  = pend ? ptgt : fpc + 32'd4;
                    pend_nxt = 1'b0;
                end
                if (take_redir) begin
                    if (head_valid) begin
                        flush    = 1'b1;
                        enq      = 1'b0;
                        pend_nxt = 1'b0;
                        // Keep fpc on the outstanding address so imem_addr stays
                        // stable; the target is applied when the drained ack lands.
                        if (imem_req && !imem_ack) begin
                            state_nxt = DRAIN;
                            ptgt_nxt  = tgt;
                            fpc_nxt   = fpc;
                        end else begin
                            fpc_nxt = tgt;
                        end
                    end else if (accept) begin
                        fpc_nxt = tgt;
                    end else begin
                        pend_nxt = 1'b1;
                        ptgt_nxt = tgt;
                    end
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (take_redir) ptgt_nxt = tgt;
                if (imem_ack) begin
                    fpc_nxt   = ptgt_nxt;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET;
            fpc   <= RESET_VECTOR;
            ptgt  <= RESET_VECTOR;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            ptgt  <= ptgt_nxt;
            pend  <= pend_nxt;
        end
    end

    ifetch_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq        (enq),
        .enq_data   ('{word: imem_rdata, pc: fpc}),
        .deq        (deq),
        .flush      (flush),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign instruction = head_valid ? head.word : NOP_INSTR;
    assign delay       = head_valid ? head.pc + 32'd4 : 32'd0;
    assign delay2      = head_valid ? head.pc + 32'd8 : 32'd0;
    assign bubble      = !head_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed reset/stall/redirect/wrap cases, then random
// stall/ack/redirect traffic checked against a program-order stream model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect, imem_ack;
    logic [31:0] redirect_target;
    logic        imem_req, bubble;
    logic [31:0] imem_addr, imem_rdata, instruction, delay, delay2;

    logic        rst_n_w, req_w, bub_w;
    logic [31:0] addr_w, rdata_w, instr_w, dly_w, dly2_w;

    int          n_vec = 0, n_err = 0;
    logic        found, af, hf;
    int          na, nh;
    logic [31:0] addrs [3];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEADBEEF;
    assign rdata_w    = mem_word(addr_w);

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .delay(delay), .delay2(delay2), .bubble(bubble)
    );

    instr_fetch #(.RESET_VECTOR(32'hFFFFFFF8)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(1'b1), .imem_rdata(rdata_w), .instruction(instr_w),
        .delay(dly_w), .delay2(dly2_w), .bubble(bub_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        stall = 0; redirect = 0; imem_ack = 0; redirect_target = 0;
        @(negedge clk); rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // Random phase model: expected next consumed pc plus at most one deferred target.
    task automatic run_random(input int cycles);
        logic [31:0] exp_pc, tgt, prev_addr;
        logic        tgt_pend, prev_wait;
        int          cool, consumed;
        exp_pc = 0; tgt = 0; tgt_pend = 0; cool = 2; consumed = 0;
        prev_wait = 0; prev_addr = 0;
        do_reset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            if (prev_wait) begin
                chk("req_hold", imem_req, 1'b1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            stall    = ($urandom_range(0, 3) == 0);
            imem_ack = ($urandom_range(0, 2) != 0);
            redirect = 0;
            if (!stall && cool == 0 && !tgt_pend && $urandom_range(0, 5) == 0) begin
                redirect = 1;
                redirect_target = $urandom;
            end
            if (!bubble && !stall) begin
                chk("rnd_instr", instruction, mem_word(exp_pc));
                chk("rnd_delay", delay, exp_pc + 32'd4);
                chk("rnd_delay2", delay2, exp_pc + 32'd8);
                exp_pc = tgt_pend ? tgt : exp_pc + 32'd4;
                tgt_pend = 0;
                if (cool > 0) cool--;
                consumed++;
                if (redirect) begin
                    exp_pc = {redirect_target[31:2], 2'b00};
                    cool = 2;
                end
            end else if (redirect) begin
                tgt_pend = 1;
                tgt = {redirect_target[31:2], 2'b00};
                cool = 2;
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
        chk("rnd_progress", consumed > cycles / 8, 1'b1);
    endtask

    initial begin
        rst_n = 0; rst_n_w = 0; stall = 0; redirect = 0; imem_ack = 1; redirect_target = 0;

        // Reset with ack tied high, then zero-wait fetch from pc 0
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instruction, 32'h00000015);
        chk("rst_delay", delay, 32'h0);
        chk("rst_delay2", delay2, 32'h0);
        chk("rst_bubble", bubble, 1'b1);
        rst_n = 1; #1;
        chk("rel0_req", imem_req, 1'b0);
        na = 0;
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) chk("c1_req", imem_req, 1'b1);
            if (c == 2) begin
                chk("c2_bubble", bubble, 1'b0);
                chk("c2_instr", instruction, mem_word(32'h0));
                chk("c2_delay", delay, 32'h4);
                chk("c2_delay2", delay2, 32'h8);
            end
            if (imem_req && na < 3) begin addrs[na] = imem_addr; na++; end
        end
        chk("seq_count", na, 3);
        for (int i = 0; i < 3; i++) chk("seq_addr", addrs[i], 32'(4 * i));

        // Stall holds head at pc 8 for 4 cycles, then pc 12 follows
        do_reset(); imem_ack = 1; found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bubble && delay == 32'd12) begin found = 1; break; end
        end
        chk("stall_find", found, 1'b1);
        stall = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("stall_instr", instruction, mem_word(32'd8));
            chk("stall_delay", delay, 32'd12);
        end
        stall = 0;
        @(negedge clk);
        for (int c = 0; c < 10 && bubble; c++) @(negedge clk);
        chk("post_stall_delay", delay, 32'd16);
        chk("post_stall_instr", instruction, mem_word(32'd12));

        // Redirect with head valid at 0x10; 0x14 must never be delivered
        do_reset(); found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bubble && delay == 32'h14) begin found = 1; break; end
            imem_ack = imem_req && imem_addr <= 32'h10;
        end
        chk("hv_find", found, 1'b1);
        chk("hv_slot", instruction, mem_word(32'h10));
        imem_ack = 0; redirect = 1; redirect_target = 32'h100;
        af = 0; hf = 0;
        for (int c = 0; c < 20 && !hf; c++) begin
            @(negedge clk);
            redirect = 0;
            imem_ack = (c >= 2);
            if (imem_req && imem_addr != 32'h14 && !af) begin
                af = 1;
                chk("hv_next_addr", imem_addr, 32'h100);
            end
            if (!bubble) begin
                hf = 1;
                chk("hv_head_delay", delay, 32'h104);
                chk("hv_head_instr", instruction, mem_word(32'h100));
            end
        end
        chk("hv_done", {af, hf}, 2'b11);

        // Redirect with head empty while 0x20 is pending; 0x20 is the delay slot
        do_reset(); found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            imem_ack = imem_req && imem_addr < 32'h20;
            if (bubble && imem_req && imem_addr == 32'h20) begin found = 1; break; end
        end
        chk("he_find", found, 1'b1);
        redirect = 1; redirect_target = 32'h203;
        af = 0; nh = 0;
        for (int c = 0; c < 30 && nh < 2; c++) begin
            @(negedge clk);
            redirect = 0;
            imem_ack = (c >= 1);
            if (imem_req && imem_addr != 32'h20 && !af) begin
                af = 1;
                chk("he_next_addr", imem_addr, 32'h200);
            end
            if (!bubble) begin
                if (nh == 0) chk("he_slot_instr", instruction, mem_word(32'h20));
                else         chk("he_tgt_delay", delay, 32'h204);
                nh++;
            end
        end
        chk("he_heads", nh, 2);

        // Reset asserted mid-cycle while a request is outstanding
        do_reset(); imem_ack = 1;
        repeat (6) @(negedge clk);
        imem_ack = 0; found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) begin found = 1; break; end
        end
        chk("mid_req_up", found, 1'b1);
        chk("mid_addr_moved", imem_addr != 32'h0, 1'b1);
        #2 rst_n = 0; #1;
        chk("mid_req", imem_req, 1'b0);
        chk("mid_bubble", bubble, 1'b1);
        chk("mid_addr", imem_addr, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1; imem_ack = 1; #1;
        chk("mid_rel_req", imem_req, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!bubble) break;
        end
        chk("mid_restart", instruction, mem_word(32'h0));

        // Wrap-around from RESET_VECTOR 0xFFFFFFF8
        @(negedge clk); rst_n_w = 1;
        na = 0; found = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_w && na < 3) begin addrs[na] = addr_w; na++; end
            if (!bub_w && instr_w == mem_word(32'hFFFFFFFC) && !found) begin
                found = 1;
                chk("wrap_delay", dly_w, 32'h0);
                chk("wrap_delay2", dly2_w, 32'h4);
            end
        end
        chk("wrap_count", na, 3);
        chk("wrap_addr0", addrs[0], 32'hFFFFFFF8);
        chk("wrap_addr1", addrs[1], 32'hFFFFFFFC);
        chk("wrap_addr2", addrs[2], 32'h00000000);
        chk("wrap_seen", found, 1'b1);
        rst_n_w = 0;

        run_random(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
